fpu_sqrt_scheduler: RTL and testbench

Shared iterative single-precision square-root unit with round-robin arbitration between `NUM_REQUESTERS` requesters. Accepts one `fpu_float_fields_t` operand at a time, runs a radix-2 restoring square root with one step per cycle, and returns the result tagged with the requester index. It sits beside the FPU pipeline so several issue ports can share one sqrt datapath instead of instantiating one each.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fpu_sqrt_step.sv | 27 ++
 rtl/fpu_sqrt_scheduler.sv | 141 ++++++++++++++
 tb/tb_fpu_sqrt_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU types plus the square-root scheduler's step record, FSM states and step count.
package fpu_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } fpu_float_fields_t;

    localparam fpu_float_fields_t FPU_FLOAT_NAN  = '{sign: 1'b0, exponent: 8'hFF, mantissa: 23'h400000};
    localparam fpu_float_fields_t FPU_FLOAT_ZERO = '{sign: 1'b0, exponent: 8'h00, mantissa: 23'h000000};

    // Working state of the restoring square root; radicand is consumed two bits per step from the top.
    typedef struct packed {
        logic [25:0] remainder;
        logic [23:0] root;
        logic [47:0] radicand;
    } fpu_sqrt_step_t;

    typedef enum logic [1:0] {
        SQ_IDLE,
        SQ_ITERATE,
        SQ_DONE
    } fpu_sqrt_sched_state_t;

    localparam int FPU_SQRT_STEPS = 24;

endpackage

// File: rtl/fpu_sqrt_step.sv
// One radix-2 restoring square-root iteration, purely combinational.
module fpu_sqrt_step
    import fpu_pkg::*;
(
    input  fpu_sqrt_step_t step_in,
    output fpu_sqrt_step_t step_out
);

    logic        [25:0] rem_shift;
    logic signed [28:0] trial;

    always_comb begin
        rem_shift = {step_in.remainder[23:0], step_in.radicand[47:46]};
        // Full-width difference so the sign decides restore vs keep without truncation surprises.
        trial = $signed({1'b0, step_in.remainder, step_in.radicand[47:46]})
              - $signed({3'b000, step_in.root, 2'b01});
        step_out.radicand = {step_in.radicand[45:0], 2'b00};
        if (trial >= 0) begin
            step_out.remainder = trial[25:0];
            step_out.root      = {step_in.root[22:0], 1'b1};
        end else begin
            step_out.remainder = rem_shift;
            step_out.root      = {step_in.root[22:0], 1'b0};
        end
    end

endmodule

// File: rtl/fpu_sqrt_scheduler.sv
// Round-robin shared iterative single-precision square root; results are tagged with the issuing requester.
module fpu_sqrt_scheduler
    import fpu_pkg::*;
#(
    parameter int NUM_REQUESTERS = 2,
    parameter int ID_WIDTH       = $clog2(NUM_REQUESTERS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic              [NUM_REQUESTERS-1:0] in_valid,
    output logic              [NUM_REQUESTERS-1:0] in_ready,
    input  fpu_float_fields_t [NUM_REQUESTERS-1:0] in_data,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output fpu_float_fields_t                     out_data,
    output logic              [ID_WIDTH-1:0]      out_id
);

    fpu_sqrt_sched_state_t state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    fpu_sqrt_step_t        step_q, step_d, step_out;
    logic [7:0]            res_exp_q, res_exp_d;
    fpu_float_fields_t     out_data_q, out_data_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;

    logic                  grant_found;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [ID_WIDTH-1:0]   scan_idx;
    logic                  accept;
    fpu_float_fields_t     op;
    logic signed [8:0]     e_unb;

    function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQUESTERS) s = s - NUM_REQUESTERS;
        return ID_WIDTH'(s);
    endfunction

    // Scan from the highest offset down so the closest valid requester to rr_ptr wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            scan_idx = rr_index(rr_ptr_q, k);
            if (in_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_ready
            assign in_ready[gi] = (state_q == SQ_IDLE) && grant_found && (grant_idx == ID_WIDTH'(gi));
        end
    endgenerate

    assign accept = (state_q == SQ_IDLE) && grant_found;
    assign op     = in_data[grant_idx];
    assign e_unb  = $signed({1'b0, op.exponent}) - 9'sd127;

    fpu_sqrt_step u_step (
        .step_in  (step_q),
        .step_out (step_out)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        step_d     = step_q;
        res_exp_d  = res_exp_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            SQ_IDLE: begin
                if (accept) begin
                    rr_ptr_d = (grant_idx == ID_WIDTH'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
                    out_id_d = grant_idx;
                    if (op.exponent == 8'h00) begin
                        out_data_d = FPU_FLOAT_ZERO;
                        state_d    = SQ_DONE;
                    end else if (op.exponent == 8'hFF || op.sign) begin
                        out_data_d = FPU_FLOAT_NAN;
                        state_d    = SQ_DONE;
                    end else begin
                        // Odd exponents borrow one radicand bit so the halved exponent stays integral.
                        step_d.remainder = '0;
                        step_d.root      = '0;
                        step_d.radicand  = e_unb[0] ? {1'b1, op.mantissa, 24'b0}
                                                    : {1'b0, 1'b1, op.mantissa, 23'b0};
                        res_exp_d        = 8'(e_unb >>> 1) + 8'd127;
                        cnt_d            = '0;
                        state_d          = SQ_ITERATE;
                    end
                end
            end
            SQ_ITERATE: begin
                step_d = step_out;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(FPU_SQRT_STEPS - 1)) begin
                    cnt_d      = '0;
                    out_data_d = '{sign: 1'b0, exponent: res_exp_q, mantissa: step_out.root[22:0]};
                    state_d    = SQ_DONE;
                end
            end
            SQ_DONE: begin
                if (out_ready) state_d = SQ_IDLE;
            end
            default: state_d = SQ_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= SQ_IDLE;
            cnt_q      <= '0;
            step_q     <= '0;
            res_exp_q  <= '0;
            out_data_q <= '0;
            out_id_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            step_q     <= step_d;
            res_exp_q  <= res_exp_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign out_valid = (state_q == SQ_DONE);
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_fpu_sqrt_scheduler.sv
// Directed bench for the shared sqrt scheduler: scoreboard of expected results checked with immediate assertions.
module tb_fpu_sqrt_scheduler;
    import fpu_pkg::*;

    localparam int N   = 2;
    localparam int IDW = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [N-1:0]             in_valid;
    logic [N-1:0]             in_ready;
    fpu_float_fields_t [N-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    fpu_float_fields_t        out_data;
    logic [IDW-1:0]           out_id;

    typedef struct {
        logic [31:0]    data;
        logic [IDW-1:0] id;
        int             lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpu_sqrt_scheduler #(.NUM_REQUESTERS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Single requester presents an operand; the accept edge is consumed here.
    task automatic issue(input int req, input logic [31:0] d, input logic [31:0] res, input int lat);
        in_valid[req] = 1'b1;
        in_data[req]  = d;
        #1;
        check("grant", 32'(in_ready), 32'(1 << req));
        sb.push_back('{data: res, id: IDW'(req), lat: lat});
        tick();
        in_valid[req] = 1'b0;
    endtask

    // Called one cycle after the accept edge; bounded wait for out_valid, then scoreboard compare.
    task automatic collect();
        int   cyc;
        exp_t e;
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            tick();
            cyc++;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard: observed empty queue expected entry");
        end else begin
            e = sb.pop_front();
            check("latency", 32'(cyc), 32'(e.lat));
            check("valid", 32'(out_valid), 32'd1);
            check("data", out_data, e.data);
            check("id", 32'(out_id), 32'(e.id));
            $display("txn id=%0d data=%h latency=%0d", out_id, out_data, cyc);
        end
        if (out_ready) begin
            tick();
            check("back_idle", 32'(out_valid), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);

        // Normal operands
        issue(0, 32'h40800000, 32'h40000000, 25); collect();
        issue(1, 32'h40000000, 32'h3FB504F3, 25); collect();
        issue(1, 32'h3F000000, 32'h3F3504F3, 25); collect();
        issue(1, 32'h3F800000, 32'h3F800000, 25); collect();

        // Special cases
        issue(0, 32'hC0800000, FPU_FLOAT_NAN,  1); collect();
        issue(0, 32'h7F800000, FPU_FLOAT_NAN,  1); collect();
        issue(0, 32'h80000000, FPU_FLOAT_ZERO, 1); collect();
        issue(0, 32'h00000001, FPU_FLOAT_ZERO, 1); collect();

        // Both requesters continuously valid: grants alternate from rr_ptr=0
        do_reset();
        in_data[0] = 32'hC0800000;
        in_data[1] = 32'h00000001;
        in_valid   = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("alt_grant", 32'(in_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            if (i % 2 == 0) sb.push_back('{data: FPU_FLOAT_NAN,  id: 1'b0, lat: 1});
            else            sb.push_back('{data: FPU_FLOAT_ZERO, id: 1'b1, lat: 1});
            tick();
            check("alt_busy_ready", 32'(in_ready), 32'd0);
            collect();
        end
        in_valid = '0;

        // Consumer stalls in DONE while requester 1 waits
        out_ready = 1'b0;
        issue(0, 32'h40800000, 32'h40000000, 25);
        collect();
        in_valid[1] = 1'b1;
        in_data[1]  = 32'h3F800000;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, 32'h40000000);
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("post_stall_grant", 32'(in_ready), 32'd2);
        sb.push_back('{data: 32'h3F800000, id: 1'b1, lat: 25});
        tick();
        in_valid[1] = 1'b0;
        collect();

        // Reset mid-iteration drops the operand
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h40800000;
        #1;
        tick();
        in_valid[0] = 1'b0;
        repeat (12) tick();
        check("mid_iter_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_data", out_data, 32'h0);
        check("abort_id", 32'(out_id), 32'd0);
        in_data[0] = 32'h40800000;
        in_data[1] = 32'h40000000;
        in_valid   = 2'b11;
        #1;
        check("abort_rr_ptr", 32'(in_ready), 32'd1);
        sb.push_back('{data: 32'h40000000, id: 1'b0, lat: 25});
        tick();
        in_valid = '0;
        collect();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
